// File: rtl/qam_frame_tx_pkg.sv
// Shared definitions for the 64-QAM serial framer and its matching baseband receiver.
package qam_tx_pkg;
    localparam logic [11:0] HEADER_INFO = 12'hB38;
    localparam int unsigned SYM_BITS    = 6;
    localparam int unsigned HDR_BITS    = 12;

    typedef logic [SYM_BITS-1:0] sym_t;

    typedef enum logic [1:0] {
        S0_IDLE,
        S1_HEADER,
        S2_PAYLOAD,
        S3_GAP
    } tx_state_t;

    // A symbol occupies the top of the shifter so both word types leave from the same MSB.
    function automatic logic [HDR_BITS-1:0] sym_word(input sym_t s);
        return {s, {(HDR_BITS - SYM_BITS){1'b0}}};
    endfunction
endpackage

// File: rtl/qam_frame_tx_if.sv
// Upstream symbol stream: 6-bit {Q,I} words over valid/ready.
interface qam_sym_if;
    logic [5:0] sym_data;
    logic       sym_valid;
    logic       sym_ready;

    modport master (output sym_data, output sym_valid, input  sym_ready);
    modport slave  (input  sym_data, input  sym_valid, output sym_ready);
endinterface

// File: rtl/qam_frame_tx_piso_shift.sv
// Parallel-load, MSB-first shift register feeding the serial line.
module tx_piso_shift #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             q_msb
);
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign q_msb = q[WIDTH-1];
endmodule

// File: rtl/qam_frame_tx.sv
// Framer: 12-bit header, SYMS_PER_FRAME 6-bit symbols, then GAP_BITS zeros on a one-bit line.
module qam_frame_tx
    import qam_tx_pkg::*;
#(
    parameter int unsigned SYMS_PER_FRAME = 16,
    parameter int unsigned GAP_BITS       = 12,
    parameter logic [5:0]  PAD_SYM        = 6'b000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    qam_sym_if.slave   sym,
    output logic       data_out,
    output logic       sym_strobe,
    output logic       tx_active,
    output logic       frame_done,
    output logic       underrun
);
    localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    tx_state_t          state, state_next;
    logic [3:0]         bit_cnt;
    logic [7:0]         sym_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic               ready;
    logic               hdr_load;
    logic               sym_load;
    logic               sh_shift;
    logic               sh_clear;
    logic [HDR_BITS-1:0] load_word;

    logic last_hdr_bit;
    logic last_sym_bit;
    logic more_syms;
    logic gap_last;

    assign last_hdr_bit = (bit_cnt == 4'(HDR_BITS - 1));
    assign last_sym_bit = (bit_cnt == 4'(SYM_BITS - 1));
    assign more_syms    = (sym_cnt < 8'(SYMS_PER_FRAME));
    assign gap_last     = (gap_cnt == GAP_W'(GAP_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S0_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        sym_strobe = 1'b0;
        frame_done = 1'b0;
        tx_active  = 1'b0;
        hdr_load   = 1'b0;
        sym_load   = 1'b0;
        sh_shift   = 1'b0;
        sh_clear   = 1'b0;
        unique case (state)
            S0_IDLE: begin
                if (start) begin
                    hdr_load   = 1'b1;
                    state_next = S1_HEADER;
                end
            end
            S1_HEADER: begin
                tx_active = 1'b1;
                if (last_hdr_bit) begin
                    ready      = 1'b1;
                    sym_load   = 1'b1;
                    state_next = S2_PAYLOAD;
                end else begin
                    sh_shift = 1'b1;
                end
            end
            S2_PAYLOAD: begin
                tx_active = 1'b1;
                if (last_sym_bit) begin
                    sym_strobe = 1'b1;
                    if (more_syms) begin
                        ready    = 1'b1;
                        sym_load = 1'b1;
                    end else begin
                        frame_done = 1'b1;
                        sh_clear   = 1'b1;
                        state_next = S3_GAP;
                    end
                end else begin
                    sh_shift = 1'b1;
                end
            end
            S3_GAP: begin
                tx_active = 1'b1;
                if (gap_last) begin
                    state_next = S0_IDLE;
                end
            end
            default: state_next = S0_IDLE;
        endcase
    end

    assign sym.sym_ready = ready;

    // Fetch never stalls the line: a missing symbol is replaced by PAD_SYM at the same edge.
    assign load_word = hdr_load ? HEADER_INFO
                                : sym_word(sym.sym_valid ? sym.sym_data : PAD_SYM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            sym_cnt  <= '0;
            gap_cnt  <= '0;
            underrun <= 1'b0;
        end else begin
            if (hdr_load || sym_load) begin
                bit_cnt <= '0;
            end else if (sh_shift) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (hdr_load) begin
                sym_cnt <= '0;
            end else if (sym_load) begin
                sym_cnt <= sym_cnt + 8'd1;
            end

            if (state == S3_GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end

            if (hdr_load) begin
                underrun <= 1'b0;
            end else if (sym_load && !sym.sym_valid) begin
                underrun <= 1'b1;
            end
        end
    end

    tx_piso_shift #(
        .WIDTH (HDR_BITS)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (hdr_load || sym_load),
        .shift (sh_shift),
        .clear (sh_clear),
        .din   (load_word),
        .q_msb (data_out)
    );
endmodule

// File: tb/tb_qam_frame_tx.sv
// Scoreboard bench for qam_frame_tx: per-cycle expected line state plus a symbol-level loopback decoder.
module tb_qam_frame_tx;
    import qam_tx_pkg::*;

    localparam int S   = 16;
    localparam int GAP = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic data_out, sym_strobe, tx_active, frame_done, underrun;

    qam_sym_if sym ();

    qam_frame_tx #(
        .SYMS_PER_FRAME (S),
        .GAP_BITS       (GAP),
        .PAD_SYM        (6'b000000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sym        (sym),
        .data_out   (data_out),
        .sym_strobe (sym_strobe),
        .tx_active  (tx_active),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Expected per-cycle record: {data_out, tx_active, sym_strobe, frame_done, sym_ready, underrun}
    logic [5:0] exp_q[$];
    logic [6:0] pres_q[$];     // {valid, data} offered to the DUT in fetch order
    logic [5:0] sym_exp_q[$];  // symbols the line must carry, pads already substituted

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic m_und    = 1'b0;

    // Reference frame built directly from the frame format rules.
    task automatic push_frame(input int pad_idx, input int invalid_pct, input int first_sym);
        logic [5:0] data, sent;
        logic       valid;
        logic [11:0] hdr;
        hdr = HEADER_INFO;
        exp_q.push_back({5'b00000, m_und});
        m_und = 1'b0;
        for (int b = 0; b < 12; b++)
            exp_q.push_back({hdr[11-b], 1'b1, 1'b0, 1'b0, (b == 11), 1'b0});
        for (int k = 0; k < S; k++) begin
            data  = (k == 0 && first_sym >= 0) ? 6'(first_sym) : 6'($urandom);
            valid = (k == pad_idx) ? 1'b0 : (int'($urandom_range(99)) >= invalid_pct);
            pres_q.push_back({valid, data});
            sent = valid ? data : 6'b000000;
            sym_exp_q.push_back(sent);
            if (!valid) m_und = 1'b1;
            for (int b = 0; b < 6; b++)
                exp_q.push_back({sent[5-b], 1'b1, (b == 5), (b == 5 && k == S-1),
                                 (b == 5 && k < S-1), m_und});
        end
        for (int g = 0; g < GAP; g++)
            exp_q.push_back({5'b01000, m_und});
    endtask

    // Upstream driver: advance to the next word after each edge where sym_ready was high.
    always begin
        logic hs;
        @(negedge clk);
        hs = sym.sym_ready && !rst;
        @(posedge clk);
        #1;
        if (hs && pres_q.size() > 0) void'(pres_q.pop_front());
        if (pres_q.size() > 0) begin
            sym.sym_valid = pres_q[0][6];
            sym.sym_data  = pres_q[0][5:0];
        end else begin
            sym.sym_valid = 1'b0;
            sym.sym_data  = 6'($urandom);
        end
    end

    // Monitor: per-cycle compare and loopback decode of header and symbols.
    logic [11:0] acc = '0;
    int          frm_bit = 0;
    logic        last_und = 1'b0;
    always @(negedge clk) begin
        logic [5:0] got, e, s;
        cyc++;
        if (rst) begin
            frm_bit  = 0;
            last_und = 1'b0;
        end else begin
            got = {data_out, tx_active, sym_strobe, frame_done, sym.sym_ready, underrun};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_und = e[0];
            end else begin
                e = {5'b00000, last_und};
            end
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL line_state cycle=%0d got=%b exp=%b (d,act,stb,done,rdy,und)", cyc, got, e);
            end
            if (tx_active) begin
                acc = {acc[10:0], data_out};
                frm_bit++;
                if (frm_bit == 12) begin
                    checks++;
                    if (acc !== HEADER_INFO) begin
                        failures++;
                        $display("FAIL header_detect cycle=%0d got=%h exp=%h", cyc, acc, HEADER_INFO);
                    end
                end
                if (sym_strobe) begin
                    checks++;
                    if (sym_exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sym_decode cycle=%0d unexpected strobe", cyc);
                    end else begin
                        s = sym_exp_q.pop_front();
                        if (acc[5:0] !== s) begin
                            failures++;
                            $display("FAIL sym_decode cycle=%0d got Q=%0d I=%0d exp Q=%0d I=%0d",
                                     cyc, acc[5:3], acc[2:0], s[5:3], s[2:0]);
                        end
                    end
                end
            end else begin
                frm_bit = 0;
            end
        end
    end

    task automatic check_zero(input string name);
        logic [5:0] got;
        got = {data_out, tx_active, sym_strobe, frame_done, sym.sym_ready, underrun};
        checks++;
        if (got !== 6'b000000) begin
            failures++;
            $display("FAIL %s got=%b exp=000000", name, got);
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout remaining=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_frame(input int pad_idx, input int pct, input int first_sym);
        @(posedge clk); #1;
        start = 1'b1;
        push_frame(pad_idx, pct, first_sym);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int n;
        sym.sym_valid = 1'b0;
        sym.sym_data  = '0;
        #12;
        check_zero("reset_state");
        @(negedge clk); #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Header, fixed first symbol 101_011, no underrun
        pulse_frame(-1, 0, 6'b101011);
        wait_drain(300);
        repeat (4) @(negedge clk);

        // Third fetch underruns; flag must persist through idle, then clear on next start
        pulse_frame(2, 0, -1);
        wait_drain(300);
        repeat (6) @(negedge clk);
        pulse_frame(-1, 0, -1);
        wait_drain(300);
        repeat (2) @(negedge clk);

        // start held high: three back-to-back frames
        @(posedge clk); #1;
        start = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(-1, 20, -1);
        n = 0;
        while (exp_q.size() > 60 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        wait_drain(300);
        repeat (3) @(negedge clk);

        // start toggling randomly mid-frame must not disturb it
        pulse_frame(-1, 10, -1);
        n = 0;
        while (exp_q.size() > 20 && n < 300) begin
            @(posedge clk); #1;
            start = 1'($urandom);
            n++;
        end
        start = 1'b0;
        wait_drain(300);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of the payload
        pulse_frame(4, 30, -1);
        repeat (40) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        exp_q.delete();
        pres_q.delete();
        sym_exp_q.delete();
        m_und = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Random loopback frames
        for (int f = 0; f < 4; f++) begin
            pulse_frame(-1, 25, -1);
            wait_drain(300);
            repeat (1 + $urandom_range(3)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
